exu_commit_stage: RTL and testbench
===================================

Name: exu_commit_stage

Overview:
- Execute-stage back end. Sits directly downstream of the integer ALU.
- Captures the ALU outputs (result, compare flag, raw adder sum) together with the decoded instruction fields.
- Resolves branches and jumps, emits a one-cycle redirect to the fetch unit, and forwards a result packet to LSU/WBU.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never combinationally reaches the IDU.

Parameters:
RD_W, 5, destination register index width
RESET_VEC, 32'h0, value driven on o_redirect_pc out of reset

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous flush: discard all buffered entries
i_valid  input  1  upstream packet valid
o_ready  output  1  stage can accept a packet
i_pc  input  32  instruction PC
i_imm  input  32  sign-extended immediate
i_rd  input  RD_W  destination register
i_rd_wen  input  1  register write enable
i_funct3  input  3  branch condition select
i_is_branch  input  1  conditional branch
i_is_jal  input  1  JAL
i_is_jalr  input  1  JALR
i_mem_ren  input  1  load
i_mem_wen  input  1  store
i_alu_r  input  32  ALU result
i_alu_cmp  input  1  ALU compare flag (signed/unsigned per decode)
i_alu_add_r  input  32  ALU adder sum (a+b or a-b)
o_valid  output  1  output packet valid
i_ready  input  1  downstream can accept
o_result  output  32  writeback value
o_addr  output  32  memory address (adder sum)
o_rd  output  RD_W  destination register
o_rd_wen  output  1  write enable
o_mem_ren  output  1  load
o_mem_wen  output  1  store
o_redirect  output  1  one-cycle redirect pulse
o_redirect_pc  output  32  redirect target

Behaviour:
- Accept = i_valid & o_ready & ~i_flush. Fire = o_valid & i_ready.
- o_ready = ~skid_valid & ~i_flush, driven only from registers and i_flush; never from i_ready.
- Branch taken, evaluated at accept:
  - funct3 000: i_alu_add_r==0
  - 001: i_alu_add_r!=0
  - 100, 110: i_alu_cmp
  - 101, 111: ~i_alu_cmp
  - 010, 011: never taken
- Redirect:
  - Occurs if i_is_jal, i_is_jalr, or (i_is_branch & taken).
  - Target: JALR -> {i_alu_add_r[31:1],1'b0}. JAL or branch -> i_pc+i_imm, 32-bit wrap-around.
- Packet result: JAL/JALR -> i_pc+4 (wraps); otherwise i_alu_r. o_addr = i_alu_add_r.
- States and transitions:
  - EMPTY: accept -> ONE (main loads).
  - ONE: accept&fire -> ONE (main reloads). accept&~fire -> FULL (skid loads). fire&~accept -> EMPTY. Neither -> hold.
  - FULL: no accept possible. fire -> ONE, main<=skid. Otherwise hold.
- o_valid = main_valid. Output fields come from main and are stable while o_valid&~i_ready.
- Latency: accept in cycle N -> o_valid in N+1 (EMPTY case).
- o_redirect: registered, high exactly in cycle N+1 after a redirecting accept. Independent of downstream stall. o_redirect_pc holds the last target until the next redirect.
- i_flush:
  - Clears main_valid and skid_valid next edge and suppresses accept that cycle.
  - Does not cancel a redirect already registered.
  - Blocks a redirect from the same cycle, because no accept occurs.
- Reset (async, any time incl. mid-transfer): o_valid=0, skid empty, o_redirect=0, o_redirect_pc=RESET_VEC, all data outputs 0. In-flight packets are dropped.
- Simultaneous fire and accept in FULL cannot occur (o_ready=0).

Test Plan:
- Reset mid-stream: load FULL, pull i_rst_n low asynchronously -> o_valid=0, o_ready=1, o_redirect=0, o_redirect_pc=0 immediately.
- ADD pass-through: i_alu_r=32'h15, rd=3, wen=1, i_ready=1 -> next cycle o_valid=1, o_result=32'h15, o_rd=3, o_redirect=0.
- Backpressure: i_ready=0, send A,B -> after B o_ready=0, o_valid=1 with A. Raise i_ready -> A then B in consecutive cycles, no loss or duplication, o_ready returns to 1.
- BEQ with funct3=000, add_r=0, pc=32'h8000_0010, imm=32'hFFFF_FFF0 -> o_redirect=1 for one cycle, o_redirect_pc=32'h8000_0000. Same packet with add_r=1 -> no redirect.
- JALR with add_r=32'h8000_1003, pc=32'h8000_0100 -> o_redirect_pc=32'h8000_1002, o_result=32'h8000_0104. BLTU with cmp=1 redirects; BGEU with cmp=1 does not.
- Flush: FULL plus i_flush with i_valid=1 -> next cycle o_valid=0, incoming packet not captured, no redirect.

Source files
------------

// File: rtl/exu_commit_stage.sv
// exu_commit_stage: execute back end -- resolves branches/jumps into a one-cycle redirect and
// forwards the result packet to LSU/WBU through a 2-entry skid buffer.
module exu_commit_stage #(
  parameter int          RD_W      = 5,
  parameter logic [31:0] RESET_VEC = 32'h0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_pc,
  input  logic [31:0]     i_imm,
  input  logic [RD_W-1:0] i_rd,
  input  logic            i_rd_wen,
  input  logic [2:0]      i_funct3,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic            i_mem_ren,
  input  logic            i_mem_wen,
  input  logic [31:0]     i_alu_r,
  input  logic            i_alu_cmp,
  input  logic [31:0]     i_alu_add_r,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_result,
  output logic [31:0]     o_addr,
  output logic [RD_W-1:0] o_rd,
  output logic            o_rd_wen,
  output logic            o_mem_ren,
  output logic            o_mem_wen,
  output logic            o_redirect,
  output logic [31:0]     o_redirect_pc
);
  localparam int PW = 64 + RD_W + 3;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] main_q, skid_q, in_pkt;
  logic accept, fire, taken, redir;
  logic [31:0] target;
  assign accept = i_valid & o_ready & ~i_flush;
  assign fire = o_valid & i_ready;
  assign in_pkt = {(i_is_jal | i_is_jalr) ? i_pc + 32'd4 : i_alu_r, i_alu_add_r, i_rd,
                   i_rd_wen, i_mem_ren, i_mem_wen};
  // funct3[2] selects the compare-flag conditions, otherwise the zero test on the adder sum
  always_comb begin
    taken = i_funct3[2] ? (i_funct3[0] ? ~i_alu_cmp : i_alu_cmp)
          : (i_funct3[1] ? 1'b0 : (i_funct3[0] ? |i_alu_add_r : ~|i_alu_add_r));
    redir = i_is_jal | i_is_jalr | (i_is_branch & taken);
    target = i_is_jalr ? {i_alu_add_r[31:1], 1'b0} : i_pc + i_imm;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= EMPTY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == EMPTY) state_nxt = accept ? ONE : EMPTY;
    else if (state == ONE) state_nxt = (accept & ~fire) ? FULL : (fire & ~accept) ? EMPTY : ONE;
    else state_nxt = fire ? ONE : FULL;
    if (i_flush) state_nxt = EMPTY;
  end
  always_comb begin
    o_valid = state != EMPTY;
    o_ready = (state != FULL) & ~i_flush;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      o_redirect <= 1'b0;
      o_redirect_pc <= RESET_VEC;
    end else begin
      if (state == FULL && fire) main_q <= skid_q;
      else if (accept && (state == EMPTY || fire)) main_q <= in_pkt;
      if (state == ONE && accept && !fire) skid_q <= in_pkt;
      o_redirect <= accept & redir;
      if (accept && redir) o_redirect_pc <= target;
    end
  assign {o_result, o_addr, o_rd, o_rd_wen, o_mem_ren, o_mem_wen} = main_q;
endmodule

// File: tb/tb_exu_commit_stage.sv
// tb_exu_commit_stage: directed and random checks of the commit stage against a queue-based model.
module tb_exu_commit_stage;
  localparam int RD_W = 5;
  logic clk = 0, rst_n = 0;
  logic flush, valid, ready, rd_wen, br, jal, jalr, mren, mwen, cmp;
  logic [2:0] f3;
  logic [RD_W-1:0] rd;
  logic [31:0] pc, imm, alu_r, add_r;
  logic o_ready, o_valid, o_rd_wen, o_mem_ren, o_mem_wen, o_redirect;
  logic [31:0] o_result, o_addr, o_redirect_pc;
  logic [RD_W-1:0] o_rd;
  typedef struct {
    logic [31:0] res;
    logic [31:0] addr;
    logic [RD_W-1:0] rd;
    logic wen, ren, sw;
  } pkt_t;
  pkt_t q[$];
  logic exp_redir = 0;
  logic [31:0] exp_pc = 0;
  int passed = 0, total = 0;

  exu_commit_stage #(.RD_W(RD_W), .RESET_VEC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_pc(pc), .i_imm(imm), .i_rd(rd), .i_rd_wen(rd_wen), .i_funct3(f3),
    .i_is_branch(br), .i_is_jal(jal), .i_is_jalr(jalr), .i_mem_ren(mren), .i_mem_wen(mwen),
    .i_alu_r(alu_r), .i_alu_cmp(cmp), .i_alu_add_r(add_r), .o_valid(o_valid), .i_ready(ready),
    .o_result(o_result), .o_addr(o_addr), .o_rd(o_rd), .o_rd_wen(o_rd_wen),
    .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic taken(input logic [2:0] f, input logic c, input logic [31:0] s);
    case (f)
      3'b000: return s == 0;
      3'b001: return s != 0;
      3'b100, 3'b110: return c;
      3'b101, 3'b111: return !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    {flush, valid, rd_wen, br, jal, jalr, mren, mwen, cmp} = '0;
    f3 = 3'd2; rd = '0; pc = '0; imm = '0; alu_r = '0; add_r = 32'h1;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".valid"}, o_valid, q.size() > 0);
    chk({ctx, ".ready"}, o_ready, q.size() < 2 && !flush);
    chk({ctx, ".redirect"}, o_redirect, exp_redir);
    chk({ctx, ".redirect_pc"}, o_redirect_pc, exp_pc);
    if (q.size() > 0) begin
      chk({ctx, ".result"}, o_result, q[0].res);
      chk({ctx, ".addr"}, o_addr, q[0].addr);
      chk({ctx, ".rd"}, o_rd, q[0].rd);
      chk({ctx, ".flags"}, {o_rd_wen, o_mem_ren, o_mem_wen}, {q[0].wen, q[0].ren, q[0].sw});
    end
  endtask

  // one clock: model decides accept/fire from the driven inputs, then checks at the falling edge
  task automatic step(input string ctx);
    logic acc, fr, rdr;
    pkt_t p;
    acc = valid && q.size() < 2 && !flush;
    fr = q.size() > 0 && ready;
    rdr = jal || jalr || (br && taken(f3, cmp, add_r));
    p.res = (jal || jalr) ? pc + 32'd4 : alu_r;
    p.addr = add_r; p.rd = rd; p.wen = rd_wen; p.ren = mren; p.sw = mwen;
    @(posedge clk);
    if (fr) void'(q.pop_front());
    if (flush) q.delete();
    else if (acc) q.push_back(p);
    exp_redir = acc && rdr;
    if (exp_redir) exp_pc = jalr ? {add_r[31:1], 1'b0} : pc + imm;
    @(negedge clk);
    check_outputs(ctx);
  endtask

  initial begin
    idle();
    ready = 1;
    #12;
    check_outputs("rst0");
    chk("rst0.result", o_result, 32'h0);
    @(negedge clk);
    rst_n = 1;

    valid = 1; alu_r = 32'h15; rd = 3; rd_wen = 1; add_r = 32'h100;
    step("add");
    chk("add.result", o_result, 32'h15);
    chk("add.rd", o_rd, 3);
    idle(); step("add.drain");

    ready = 0; valid = 1; alu_r = 32'hAAAA; rd = 1; rd_wen = 1;
    step("bp.a");
    alu_r = 32'hBBBB; rd = 2; mwen = 1; rd_wen = 0;
    step("bp.b");
    chk("bp.full_ready", o_ready, 0);
    chk("bp.hold_a", o_result, 32'hAAAA);
    idle(); ready = 1;
    step("bp.out_b");
    chk("bp.b_second", o_result, 32'hBBBB);
    step("bp.empty");

    valid = 1; br = 1; f3 = 3'b000; add_r = 0; pc = 32'h8000_0010; imm = 32'hFFFF_FFF0;
    step("beq.t");
    chk("beq.t.redirect", o_redirect, 1);
    chk("beq.t.target", o_redirect_pc, 32'h8000_0000);
    idle(); step("beq.pulse_end");
    chk("beq.one_cycle", o_redirect, 0);
    valid = 1; br = 1; f3 = 3'b000; add_r = 1; pc = 32'h8000_0010; imm = 32'hFFFF_FFF0;
    step("beq.nt");
    chk("beq.nt.redirect", o_redirect, 0);

    idle(); valid = 1; jalr = 1; add_r = 32'h8000_1003; pc = 32'h8000_0100;
    step("jalr");
    chk("jalr.target", o_redirect_pc, 32'h8000_1002);
    chk("jalr.link", o_result, 32'h8000_0104);
    idle(); valid = 1; br = 1; f3 = 3'b110; cmp = 1; pc = 32'h40; imm = 32'h20;
    step("bltu");
    chk("bltu.redirect", o_redirect, 1);
    chk("bltu.target", o_redirect_pc, 32'h60);
    f3 = 3'b111;
    step("bgeu");
    chk("bgeu.redirect", o_redirect, 0);

    idle(); ready = 0; valid = 1; alu_r = 32'h1;
    step("fl.a");
    alu_r = 32'h2;
    step("fl.b");
    jal = 1; flush = 1; pc = 32'h100; imm = 32'h40;
    step("fl.flush");
    chk("fl.valid", o_valid, 0);
    chk("fl.no_redirect", o_redirect, 0);
    idle(); ready = 1;
    step("fl.after");

    ready = 0; valid = 1; jal = 1; pc = 32'h200; imm = 32'h8;
    step("mr.a");
    jal = 0; alu_r = 32'h77;
    step("mr.b");
    idle();
    #2 rst_n = 0;
    #1;
    q.delete(); exp_redir = 0; exp_pc = 0;
    check_outputs("mr.reset");
    chk("mr.result", o_result, 32'h0);
    @(negedge clk);
    rst_n = 1;
    step("mr.idle");

    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(15) == 0);
      valid = $urandom_range(3) != 0;
      ready = $urandom_range(2) != 0;
      pc = $urandom; imm = $urandom; alu_r = $urandom; rd = RD_W'($urandom);
      add_r = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      cmp = 1'($urandom); f3 = 3'($urandom); rd_wen = 1'($urandom);
      mren = 1'($urandom); mwen = 1'($urandom);
      {br, jal, jalr} = '0;
      case ($urandom_range(3))
        0: br = 1;
        1: jal = 1;
        2: jalr = 1;
        default: ;
      endcase
      step("rnd");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
